// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the FFT frame scheduler.
// Stats helper is only referenced when FFT_SCHED_STATS_EN is defined.
package fft_pkg;
   localparam int LANES  = 16;
   localparam int BEATS  = 32;
   localparam int DIN_W  = 9;
   localparam int LANE_W = LANES * DIN_W;
   localparam int CNT_W  = $clog2(BEATS);
   localparam int ADDR_W = CNT_W + 1;

   localparam logic [CNT_W-1:0] LAST_BEAT    = CNT_W'(BEATS - 1);
   localparam logic [1:0]       MAX_INFLIGHT = 2'd2;
   localparam logic [7:0]       TIMEOUT      = 8'd255;

   typedef enum logic {IDLE, BURST} sched_state_t;

   typedef struct packed {
      logic [LANE_W-1:0] re;
      logic [LANE_W-1:0] im;
   } beat_t;

   function automatic logic [15:0] sat_inc(
      input logic [15:0] v,
      input logic        en
   );
      return (en && v != 16'hFFFF) ? v + 16'd1 : v;
   endfunction
endpackage

// File: rtl/fft_frame_scheduler_if.sv
// fft_frame_scheduler_if: upstream beat handshake and FFT-facing signals.
// slave = scheduler side, master = upstream source / FFT side.
interface fft_frame_scheduler_if;
   import fft_pkg::*;

   logic              s_valid;
   logic              s_ready;
   logic [LANE_W-1:0] s_re;
   logic [LANE_W-1:0] s_im;
   logic              fft_valid;
   logic [LANE_W-1:0] fft_re;
   logic [LANE_W-1:0] fft_im;
   logic              fft_oen;
   logic              m_sof;
   logic              m_eof;

   modport master (
      output s_valid, s_re, s_im, fft_oen,
      input  s_ready, fft_valid, fft_re, fft_im, m_sof, m_eof
   );

   modport slave (
      input  s_valid, s_re, s_im, fft_oen,
      output s_ready, fft_valid, fft_re, fft_im, m_sof, m_eof
   );
endinterface

// File: rtl/fft_pingpong_buf.sv
// fft_pingpong_buf: two BEATS-deep banks with full flags and write pointer.
// Registered read port; output is zero whenever no read is requested.
module fft_pingpong_buf
   import fft_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  beat_t             wdata,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              rd_done,
   input  logic              rd_bank,
   output logic [1:0]        full,
   output logic              wr_full,
   output beat_t             rdata
);
   beat_t            mem [2*BEATS];
   logic             wr_bank;
   logic [CNT_W-1:0] wr_cnt;
   logic [1:0]       full_n;
   logic             frame_in;

   assign wr_full  = full[wr_bank];
   assign frame_in = wr_en && wr_cnt == LAST_BEAT;

   // release and fill on the same edge both land
   always_comb begin
      full_n = full;
      if (rd_done) full_n[rd_bank] = 1'b0;
      if (frame_in) full_n[wr_bank] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[{wr_bank, wr_cnt}] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bank <= 1'b0;
         wr_cnt  <= '0;
         full    <= '0;
         rdata   <= '0;
      end else begin
         full  <= full_n;
         rdata <= rd_en ? mem[raddr] : '0;
         if (wr_en) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (frame_in) wr_bank <= ~wr_bank;
         end
      end
   end
endmodule

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: ping-pong framing of beats into gap-free FFT bursts.
// Define FFT_SCHED_STATS_EN to add saturating frame/stall counters.
module fft_frame_scheduler
   import fft_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   fft_frame_scheduler_if.slave bus,
   input  logic                 clr_err,
   output logic [1:0]           inflight,
   output logic                 err_timeout
`ifdef FFT_SCHED_STATS_EN
   ,
   output logic [15:0]          stat_frames_in,
   output logic [15:0]          stat_frames_out,
   output logic [15:0]          stat_stall
`endif
);
   sched_state_t      state, state_n;
   logic [CNT_W-1:0]  rd_cnt, cnt_n, oc;
   logic              rd_bank, rd_bank_n;
   logic              start, done, room, rdy;
   logic              accept, wr_full;
   logic              counted, dec, idle_tick, set_err;
   logic [1:0]        full;
   logic [7:0]        wd;
   beat_t             wdata, rdata;

   assign room         = inflight < MAX_INFLIGHT;
   assign bus.s_ready  = rdy && !wr_full;
   assign accept       = bus.s_valid && bus.s_ready;
   assign wdata        = {bus.s_re, bus.s_im};
   assign bus.fft_re   = rdata.re;
   assign bus.fft_im   = rdata.im;

   always_comb begin
      state_n = state;
      start   = 1'b0;
      done    = 1'b0;
      unique case (state)
         IDLE: if (full[rd_bank] && room) begin
            state_n = BURST;
            start   = 1'b1;
         end
         BURST: if (rd_cnt == LAST_BEAT) begin
            done = 1'b1;
            if (full[~rd_bank] && room) start = 1'b1;
            else state_n = IDLE;
         end
      endcase
   end

   // prefetch address: where the next issued beat lives
   assign rd_bank_n = rd_bank ^ done;
   assign cnt_n     = (state == BURST) ? rd_cnt + 1'b1 : '0;

   fft_pingpong_buf u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept),
      .wdata   (wdata),
      .rd_en   (state_n == BURST),
      .raddr   ({rd_bank_n, cnt_n}),
      .rd_done (done),
      .rd_bank (rd_bank),
      .full    (full),
      .wr_full (wr_full),
      .rdata   (rdata)
   );

   assign bus.m_sof = bus.fft_oen && oc == '0;
   assign bus.m_eof = bus.fft_oen && oc == LAST_BEAT;
   assign counted   = bus.fft_oen && inflight != 2'd0;
   assign dec       = counted && oc == LAST_BEAT;
   assign idle_tick = !bus.fft_oen && inflight != 2'd0;
   assign set_err   = (bus.fft_oen && inflight == 2'd0)
                    || (idle_tick && wd == TIMEOUT - 8'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         rd_cnt        <= '0;
         rd_bank       <= 1'b0;
         rdy           <= 1'b0;
         bus.fft_valid <= 1'b0;
         inflight      <= '0;
         oc            <= '0;
         wd            <= '0;
         err_timeout   <= 1'b0;
      end else begin
         state         <= state_n;
         rd_cnt        <= cnt_n;
         rd_bank       <= rd_bank_n;
         rdy           <= 1'b1;
         bus.fft_valid <= state_n == BURST;
         inflight      <= inflight + {1'b0, start} - {1'b0, dec};
         if (counted) oc <= oc + 1'b1;
         if (clr_err || bus.fft_oen) wd <= '0;
         else if (idle_tick && wd != TIMEOUT) wd <= wd + 8'd1;
         err_timeout <= !clr_err && (err_timeout || set_err);
      end
   end

`ifdef FFT_SCHED_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_frames_in  <= '0;
         stat_frames_out <= '0;
         stat_stall      <= '0;
      end else if (clr_err) begin
         stat_frames_in  <= '0;
         stat_frames_out <= '0;
         stat_stall      <= '0;
      end else begin
         stat_frames_in  <= sat_inc(stat_frames_in, start);
         stat_frames_out <= sat_inc(stat_frames_out, dec);
         stat_stall      <= sat_inc(stat_stall, bus.s_valid && !bus.s_ready);
      end
   end
`endif
endmodule
